// File: rtl/jtag_ir_dr.sv
// JTAG instruction register plus BYPASS / IDCODE / USER data registers and TDO mux.
// Driven by the TAP controller's one-hot capture/shift/update strobes on tck.
module jtag_ir_dr #(
  parameter int              IR_W    = 4,
  parameter int              DR_W    = 32,
  parameter logic [31:0]     IDCODE  = 32'h1000_0001,
  parameter logic [IR_W-1:0] OP_ID   = 4'h1,
  parameter logic [IR_W-1:0] OP_USER = 4'h8
) (
  input  logic            tck,
  input  logic            reset,
  input  logic            tdi,
  input  logic            capir,
  input  logic            shiftir,
  input  logic            updateir,
  input  logic            capdr,
  input  logic            shiftdr,
  input  logic            updatedr,
  output logic            tdo,
  output logic [IR_W-1:0] ir_out,
  output logic            user_sel,
  input  logic [DR_W-1:0] user_cap_data,
  output logic [DR_W-1:0] user_upd_data,
  output logic            user_upd_stb
);

  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);

  logic [IR_W-1:0] ir_latch_reg;
  logic [IR_W-1:0] ir_sr_reg;
  logic            bp_reg;
  logic [31:0]     id_sr_reg;
  logic [DR_W-1:0] usr_sr_reg;
  logic [DR_W-1:0] usr_shift_next;
  logic [DR_W-1:0] user_upd_data_reg;
  logic            user_upd_stb_reg;

  logic sel_id, sel_user, sel_bp;
  logic cap_any, shift_any;
  logic do_shift_ir, do_shift_dr, do_upd_ir, do_upd_dr;

  assign sel_id   = (ir_latch_reg == OP_ID);
  assign sel_user = (ir_latch_reg == OP_USER);
  assign sel_bp   = !sel_id && !sel_user;

  // Misuse with overlapping strobes resolves as capture > shift > update.
  assign cap_any     = capir | capdr;
  assign shift_any   = shiftir | shiftdr;
  assign do_shift_ir = shiftir & ~cap_any;
  assign do_shift_dr = shiftdr & ~cap_any;
  assign do_upd_ir   = updateir & ~cap_any & ~shift_any;
  assign do_upd_dr   = updatedr & ~cap_any & ~shift_any;

  generate
    if (DR_W == 1) begin : g_usr_one
      assign usr_shift_next = tdi;
    end else begin : g_usr_many
      assign usr_shift_next = {tdi, usr_sr_reg[DR_W-1:1]};
    end
  endgenerate

  always_ff @(posedge tck) begin
    if (reset) begin
      ir_latch_reg      <= OP_ID;
      ir_sr_reg         <= '0;
      bp_reg            <= 1'b0;
      id_sr_reg         <= '0;
      usr_sr_reg        <= '0;
      user_upd_data_reg <= '0;
      user_upd_stb_reg  <= 1'b0;
    end else begin
      if (capir) begin
        ir_sr_reg <= IR_CAPTURE;
      end else if (do_shift_ir) begin
        ir_sr_reg <= {tdi, ir_sr_reg[IR_W-1:1]};
      end

      if (do_upd_ir) begin
        ir_latch_reg <= ir_sr_reg;
      end

      if (capdr) begin
        if (sel_bp)   bp_reg     <= 1'b0;
        if (sel_id)   id_sr_reg  <= IDCODE;
        if (sel_user) usr_sr_reg <= user_cap_data;
      end else if (do_shift_dr) begin
        if (sel_bp)   bp_reg     <= tdi;
        if (sel_id)   id_sr_reg  <= {tdi, id_sr_reg[31:1]};
        if (sel_user) usr_sr_reg <= usr_shift_next;
      end

      // Strobe is registered so it lines up with the freshly latched data.
      user_upd_stb_reg <= do_upd_dr & sel_user;
      if (do_upd_dr && sel_user) begin
        user_upd_data_reg <= usr_sr_reg;
      end
    end
  end

  always_comb begin
    tdo = bp_reg;
    if (shiftir) begin
      tdo = ir_sr_reg[0];
    end else if (sel_id) begin
      tdo = id_sr_reg[0];
    end else if (sel_user) begin
      tdo = usr_sr_reg[0];
    end
  end

  assign ir_out        = ir_latch_reg;
  assign user_sel      = sel_user;
  assign user_upd_data = user_upd_data_reg;
  assign user_upd_stb  = user_upd_stb_reg;

endmodule
